rob_retire: RTL
===============

# rob_retire

In-order retirement queue producing the tag-return stream for `tagfifo`. It records each 5-bit ROB tag as dispatch pops it from the tag free list. It marks the tag complete when that tag's result appears on the CDB. It then returns completed tags to `tagfifo` strictly in dispatch order through `RB_Tag`/`RB_Tag_Valid`, at most one per cycle.

## Interface
- `DEPTH`, 32: queue entries; equals tag space 2^`TAG_W`.
- `TAG_W`, 5: tag width.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `Disp_Tag`  in  TAG_W  tag allocated at dispatch (from `tagfifo` `Tag_Out`).
- `Disp_Valid`  in  1  dispatch allocates `Disp_Tag` this cycle.
- `Cdb_Tag`  in  TAG_W  tag whose result broadcasts this cycle.
- `Cdb_Valid`  in  1  CDB broadcast valid.
- `Commit_Stall`  in  1  blocks retirement this cycle.
- `Flush`  in  1  mispredict flush (present only with `ROB_FLUSH_EN`).
- `RB_Tag`  out  TAG_W  returned tag, registered.
- `RB_Tag_Valid`  out  1  one-cycle pulse per returned tag, registered.
- `Rob_Full`  out  1  count == DEPTH.
- `Rob_Empty`  out  1  count == 0.
- `Rob_Count`  out  TAG_W+1  entries held.
- `Rob_Busy`  out  1  high while draining; tied 0 without `ROB_FLUSH_EN`.

## Operation
- Storage: `tag[DEPTH]`, `done[DEPTH]`, `head`/`tail` TAG_W bits wrapping naturally modulo DEPTH, `count` TAG_W+1 bits.
- Dispatch: `Disp_Valid && !Rob_Full` in RUN writes `tag[tail]`, clears `done[tail]`, and increments `tail`. `Disp_Valid` while full is dropped with no state change.
- Full is evaluated before the current cycle's retire; dispatch and retire in the same full cycle means the retire happens and the dispatch is dropped.
- Completion: `Cdb_Valid` compares `Cdb_Tag` against every occupied entry (head..tail-1). A match sets `done`. A tag written by a dispatch in the same cycle is not matched. A miss is ignored.
- Retire, RUN: if `count != 0 && done[head] && !Commit_Stall`, then `RB_Tag <= tag[head]`, `RB_Tag_Valid <= 1`, `head++`, `count--`. Otherwise `RB_Tag_Valid <= 0` and `RB_Tag` holds its value.
- A non-done head blocks younger done entries.
- Simultaneous dispatch and retire leaves `count` unchanged.
- FSM: RUN, DRAIN. DRAIN exists only with `ROB_FLUSH_EN`.
  - RUN → DRAIN: `Flush && count != 0`.
  - `Flush` with count 0: no effect.
  - DRAIN: returns `tag[head]` every cycle regardless of `done` and `Commit_Stall`. Dispatch, CDB and further `Flush` are ignored.
  - DRAIN → RUN: on the cycle the last entry is returned (count reaches 0).
- Reset (`reset == 0` at an edge), including mid-drain: head = tail = count = 0, all `done` cleared, state RUN. Tags in flight are not returned; `tagfifo` reset restores the free list.

## Timing
- Reset values: `RB_Tag`=0, `RB_Tag_Valid`=0, `Rob_Full`=0, `Rob_Empty`=1, `Rob_Count`=0, `Rob_Busy`=0.
- All outputs are registered or derived directly from registers; there are no combinational input-to-output paths.
- Dispatch sampled at edge N: entry visible in `Rob_Count` after edge N. The earliest completion is a CDB at edge N+1.
- CDB sampled at edge N on the head entry: `RB_Tag_Valid` is high in the cycle following edge N+1 (two-edge latency, no bypass).
- Throughput: one retire per cycle.
- `Flush` sampled at edge N with k entries: `Rob_Busy` high after edge N. `RB_Tag_Valid` is high for k consecutive cycles starting after edge N+1. `Rob_Busy` falls after the edge that returns the last tag.

## Configuration
- `ROB_FLUSH_EN` defined: `Flush` port and DRAIN state are present; `Rob_Busy` is live.
- `ROB_FLUSH_EN` undefined: no `Flush` port, FSM is RUN only, `Rob_Busy` is constant 0.

## Test plan
- Reset: hold `reset`=0 two cycles → all outputs at reset values; `Rob_Empty`=1, `Rob_Count`=0.
- In order: dispatch 3,7,9; CDB 3 → `RB_Tag`=3 two edges later with a one-cycle `RB_Tag_Valid` pulse; `Rob_Count`=2.
- Out of order: dispatch 3,7,9; CDB 9, then 7 → no return; then CDB 3 → returns 3,7,9 on consecutive cycles; `Rob_Empty`=1.
- Full and wrap: dispatch tags 0..31 → `Rob_Full`=1; a 33rd `Disp_Valid` is dropped; complete all 32 with `Commit_Stall` toggling → 32 returns in order 0..31; head and tail wrap to 0.
- Flush (`ROB_FLUSH_EN`): dispatch 4,5,6, complete none, pulse `Flush` → `Rob_Busy`=1; returns 4,5,6 on three consecutive cycles; `Disp_Valid` during the drain is ignored; `Rob_Busy`=0 and `Rob_Count`=0 afterwards.
- Reset mid-drain: assert `reset`=0 during the second drain cycle → no further `RB_Tag_Valid`; outputs at reset values after the edge.

Source files
------------

// File: rtl/rob_retire_if.sv
// rob_retire_if: dispatch/CDB/commit inputs and tag-return outputs of rob_retire.
// Flush exists only when ROB_FLUSH_EN is defined.
interface rob_retire_if #(
    parameter int TAG_W = 5
);
    logic [TAG_W-1:0] Disp_Tag;
    logic             Disp_Valid;
    logic [TAG_W-1:0] Cdb_Tag;
    logic             Cdb_Valid;
    logic             Commit_Stall;
`ifdef ROB_FLUSH_EN
    logic             Flush;
`endif
    logic [TAG_W-1:0] RB_Tag;
    logic             RB_Tag_Valid;
    logic             Rob_Full;
    logic             Rob_Empty;
    logic [TAG_W:0]   Rob_Count;
    logic             Rob_Busy;

    modport master (
`ifdef ROB_FLUSH_EN
        output Flush,
`endif
        output Disp_Tag, Disp_Valid, Cdb_Tag, Cdb_Valid, Commit_Stall,
        input  RB_Tag, RB_Tag_Valid, Rob_Full, Rob_Empty, Rob_Count, Rob_Busy
    );
    modport slave (
`ifdef ROB_FLUSH_EN
        input  Flush,
`endif
        input  Disp_Tag, Disp_Valid, Cdb_Tag, Cdb_Valid, Commit_Stall,
        output RB_Tag, RB_Tag_Valid, Rob_Full, Rob_Empty, Rob_Count, Rob_Busy
    );
endinterface

// File: rtl/rob_retire.sv
// rob_retire: in-order retirement queue returning completed tags to tagfifo.
// ROB_FLUSH_EN adds the Flush input and a DRAIN state that returns every held tag.
module rob_retire #(
    parameter int DEPTH = 32,
    parameter int TAG_W = 5
) (
    input logic         clock,
    input logic         reset,
    rob_retire_if.slave rb
);
    typedef enum logic {RUN, DRAIN} state_e;
    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);
    state_e           state_q, state_d;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [DEPTH-1:0] done_q, done_d;
    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, rb_tag_q, rb_tag_d;
    logic [TAG_W:0]   count_q, count_d;
    logic             rb_valid_q, rb_valid_d;
    logic             full, run, flush_w, flush_go, disp, ret;
`ifdef ROB_FLUSH_EN
    assign flush_w = rb.Flush;
`else
    assign flush_w = 1'b0;
`endif
    // the flush cycle itself neither dispatches nor retires, so all k held entries drain afterwards
    always_comb begin
        full       = count_q == FULL_CNT;
        run        = state_q == RUN;
        flush_go   = run && flush_w && count_q != '0;
        disp       = run && !flush_go && rb.Disp_Valid && !full;
        ret        = count_q != '0 && (!run || (!flush_go && done_q[head_q] && !rb.Commit_Stall));
        head_d     = head_q + TAG_W'(ret);
        tail_d     = tail_q + TAG_W'(disp);
        count_d    = count_q + (TAG_W+1)'(disp) - (TAG_W+1)'(ret);
        rb_valid_d = ret;
        rb_tag_d   = ret ? tag_q[head_q] : rb_tag_q;
        state_d    = flush_go ? DRAIN : (!run && count_d == '0) ? RUN : state_q;
        done_d     = done_q;
        for (int i = 0; i < DEPTH; i++)
            if (run && rb.Cdb_Valid && tag_q[i] == rb.Cdb_Tag && {1'b0, TAG_W'(i) - head_q} < count_q)
                done_d[i] = 1'b1;
        if (disp)
            done_d[tail_q] = 1'b0;
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= RUN;
            done_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rb_tag_q   <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rb_tag_q   <= rb_tag_d;
            rb_valid_q <= rb_valid_d;
        end
    end
    always_ff @(posedge clock)
        if (disp)
            tag_q[tail_q] <= rb.Disp_Tag;
    assign rb.RB_Tag       = rb_tag_q;
    assign rb.RB_Tag_Valid = rb_valid_q;
    assign rb.Rob_Full     = count_q == FULL_CNT;
    assign rb.Rob_Empty    = count_q == '0;
    assign rb.Rob_Count    = count_q;
`ifdef ROB_FLUSH_EN
    assign rb.Rob_Busy     = state_q == DRAIN;
`else
    assign rb.Rob_Busy     = 1'b0;
`endif
endmodule
